monster_lane_ctrl: RTL and testbench
====================================

MONSTER_LANE_CTRL -- requirements
Module: monster_lane_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4, meaning number of independent monster lanes, range 1..8.
REQ-002 Parameter TIMER_W, default 16, meaning per-lane attack timer width in bits.
REQ-003 Parameter ATTACK_TICKS, default 1000, meaning ticks from spawn until the monster fires; range 1..2^TIMER_W-1.
REQ-004 Parameter SPAWN_THRESH, default 32, meaning spawn probability numerator out of 256; range 0..256.
REQ-005 Parameter MAX_ACTIVE, default 2, meaning maximum simultaneously FULL lanes; range 1..NUM_LANES.
REQ-006 Parameter LFSR_SEED, default 8'hA5, meaning LFSR reset value; must be nonzero.
REQ-007 Port Clk  input  1  system clock; all state changes on its rising edge.
REQ-008 Port Reset  input  1  asynchronous, active-high reset.
REQ-009 Port tick  input  1  game-time strobe, one Clk cycle wide.
REQ-010 Port play  input  1  level; 1 = game requested.
REQ-011 Port shoot  input  NUM_LANES  per-lane kill pulse, one Clk cycle wide.
REQ-012 Port q_idle, q_run, q_over  output  1 each  one-hot global state flags.
REQ-013 Port lane_full  output  NUM_LANES  1 = monster present in lane i.
REQ-014 Port kills  output  8  monsters destroyed this game, saturating.
REQ-015 Port game_over  output  1  equals q_over.
REQ-016 Port over_lane  output  NUM_LANES  lanes whose timer expired on the game-ending tick.

Function
REQ-017 Global FSM has three states: IDLE, RUN, OVER; exactly one q_* flag is high at all times.
REQ-018 IDLE: lane_full=0 and all timers=0; play=1 -> RUN next cycle, clearing kills and over_lane on that transition.
REQ-019 RUN with play=0 -> IDLE next cycle; all lanes cleared; kills held.
REQ-020 OVER: lanes, timers, kills, and over_lane frozen; play=0 -> IDLE next cycle.
REQ-021 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; advances once per tick in RUN only; never reaches zero.
REQ-022 Per-lane value r_i = lfsr XOR (i*8'h3B mod 256), using the pre-advance LFSR value.
REQ-023 On a RUN tick, EMPTY lane i is a candidate when r_i < SPAWN_THRESH; SPAWN_THRESH=0 never spawns; 256 always qualifies.
REQ-024 Candidates are granted lowest index first until the post-tick FULL count reaches MAX_ACTIVE; excess candidates stay EMPTY.
REQ-025 A spawning lane becomes FULL and loads its timer with ATTACK_TICKS on the same edge.
REQ-026 On each RUN tick, each FULL lane that was not spawned on that tick decrements its timer by 1.
REQ-027 A FULL lane whose timer decrements from 1 to 0 expires.
REQ-028 Any expiry -> OVER on the same edge; over_lane bit i set for each expiring lane; all other expiring lanes are recorded too.
REQ-029 shoot[i] in RUN while lane i is FULL -> lane EMPTY, timer 0, kills+1 (saturates at 255), regardless of tick.
REQ-030 shoot[i] on an EMPTY lane, or in IDLE/OVER, has no effect.
REQ-031 Simultaneous shoot[i] and expiry of lane i in the same cycle: shoot wins, no expiry for that lane.
REQ-032 A lane shot in a cycle is not a spawn candidate until the next tick.
REQ-033 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-034 Reset asserted forces IDLE, lane_full=0, timers=0, kills=0, over_lane=0, game_over=0, lfsr=LFSR_SEED immediately, regardless of Clk.
REQ-035 Reset asserted mid-RUN or in OVER is identical to reset at power-up; first edge after deassertion evaluates IDLE.

Verification
REQ-036 THRESH=256, MAX_ACTIVE=2, NUM_LANES=4: play=1, one tick -> lane_full=4'b0011.
REQ-037 THRESH=256, MAX_ACTIVE=4, ATTACK_TICKS=3: first tick -> all FULL; shoot[2] -> kills=1; third tick after spawn -> game_over=1, over_lane=4'b1011, lane 2 respawn does not expire.
REQ-038 ATTACK_TICKS=2: shoot[0] asserted in the same cycle as lane 0's expiring tick -> lane 0 EMPTY, kills incremented, no game_over.
REQ-039 THRESH=0: 10000 ticks in RUN -> lane_full=0, game_over=0, LFSR never 0.
REQ-040 Reset pulse mid-RUN with kills=5 -> kills=0, q_idle=1, lfsr=8'hA5 before next Clk edge.
REQ-041 Kill 300 monsters -> kills=255 held; in OVER, play=0 then play=1 -> RUN with kills=0.

Source files
------------

// File: rtl/monster_lane_ctrl.sv
// -----------------------------------------------------------------------------
// monster_lane_ctrl
//   Game controller for NUM_LANES independent monster lanes. A global
//   IDLE/RUN/OVER state machine gates the lanes. An 8-bit LFSR, advanced once
//   per game tick while running, decides which empty lanes spawn a monster.
//   Each spawned monster arms a per-lane attack timer, and the game ends when
//   any timer runs out. The player removes monsters with per-lane shoot pulses.
//
// Ports
//   Clk        : system clock, all state changes on its rising edge
//   Reset      : asynchronous, active-high reset
//   tick       : one-cycle game-time strobe
//   play       : level, 1 = game requested
//   shoot      : per-lane one-cycle kill pulse
//   q_idle     : global state flag (one-hot with q_run / q_over)
//   q_run      : global state flag
//   q_over     : global state flag
//   lane_full  : 1 = monster present in lane i
//   kills      : monsters destroyed this game, saturating at 255
//   game_over  : equals q_over
//   over_lane  : lanes whose timer expired on the game-ending tick
// -----------------------------------------------------------------------------
module monster_lane_ctrl #(
  parameter int          NUM_LANES    = 4,
  parameter int          TIMER_W      = 16,
  parameter int          ATTACK_TICKS = 1000,
  parameter int          SPAWN_THRESH = 32,
  parameter int          MAX_ACTIVE   = 2,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 tick,
  input  logic                 play,
  input  logic [NUM_LANES-1:0] shoot,
  output logic                 q_idle,
  output logic                 q_run,
  output logic                 q_over,
  output logic [NUM_LANES-1:0] lane_full,
  output logic [7:0]           kills,
  output logic                 game_over,
  output logic [NUM_LANES-1:0] over_lane
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] ATTACK_T  = TIMER_W'(ATTACK_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1'b1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(1'b0);
  // 9 bits so that a threshold of 256 compares above every 8-bit value
  localparam logic [8:0]         THRESH9   = 9'(SPAWN_THRESH);
  localparam logic [3:0]         MAX_ACT4  = 4'(MAX_ACTIVE);

  // Number of set bits in a lane vector (NUM_LANES <= 8 fits in 4 bits)
  function automatic logic [3:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3)
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Per-lane decorrelation constant: i*0x3B modulo 256
  function automatic logic [7:0] lane_salt(input int i);
    return 8'(i * 32'd59);
  endfunction

  state_t               state_q, state_d;
  logic                 q_idle_q, q_idle_d;
  logic                 q_run_q,  q_run_d;
  logic                 q_over_q, q_over_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [NUM_LANES-1:0] lane_full_q, lane_full_d;
  logic [TIMER_W-1:0]   timer_q [NUM_LANES];
  logic [TIMER_W-1:0]   timer_d [NUM_LANES];
  logic [7:0]           kills_q, kills_d;
  logic [NUM_LANES-1:0] over_lane_q, over_lane_d;

  logic [NUM_LANES-1:0] kill_s;
  logic [NUM_LANES-1:0] expire_s;
  logic [3:0]           active_cnt_s;
  logic [8:0]           kill_sum_s;

  // Next-state, lane and score logic
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    lane_full_d  = lane_full_q;
    kills_d      = kills_q;
    over_lane_d  = over_lane_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      timer_d[i] = timer_q[i];
    end
    kill_s       = shoot & lane_full_q;
    expire_s     = {NUM_LANES{1'b0}};
    active_cnt_s = 4'd0;
    kill_sum_s   = {1'b0, kills_q} + {5'd0, popcount(shoot & lane_full_q)};

    case (state_q)
      ST_IDLE: begin
        lane_full_d = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
          timer_d[i] = TIMER_ZERO;
        end
        if (play) begin
          state_d     = ST_RUN;
          kills_d     = 8'd0;
          over_lane_d = {NUM_LANES{1'b0}};
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!play) begin
          state_d     = ST_IDLE;
          lane_full_d = {NUM_LANES{1'b0}};
          for (int i = 0; i < NUM_LANES; i++) begin
            timer_d[i] = TIMER_ZERO;
          end
        end else begin
          kills_d = kill_sum_s[8] ? 8'hFF : kill_sum_s[7:0];
          // Lanes that stay full after this cycle's shots occupy slots first;
          // lanes shot this cycle are still marked full in lane_full_q and so
          // can never be spawn candidates on the same edge.
          active_cnt_s = popcount(lane_full_q & ~kill_s);
          for (int i = 0; i < NUM_LANES; i++) begin
            if (kill_s[i]) begin
              lane_full_d[i] = 1'b0;
              timer_d[i]     = TIMER_ZERO;
            end else if (tick && lane_full_q[i]) begin
              timer_d[i]     = timer_q[i] - TIMER_ONE;
              expire_s[i]    = (timer_q[i] == TIMER_ONE);
            end else if (tick && ({1'b0, lfsr_q ^ lane_salt(i)} < THRESH9) &&
                         (active_cnt_s < MAX_ACT4)) begin
              lane_full_d[i] = 1'b1;
              timer_d[i]     = ATTACK_T;
              active_cnt_s   = active_cnt_s + 4'd1;
            end else begin
              lane_full_d[i] = lane_full_q[i];
              timer_d[i]     = timer_q[i];
            end
          end
          if (tick) begin
            lfsr_d = lfsr_next(lfsr_q);
          end else begin
            lfsr_d = lfsr_q;
          end
          if (|expire_s) begin
            state_d     = ST_OVER;
            over_lane_d = expire_s;
          end else begin
            state_d     = ST_RUN;
            over_lane_d = over_lane_q;
          end
        end
      end

      ST_OVER: begin
        // Everything frozen; leaving clears the lanes so IDLE starts empty
        if (!play) begin
          state_d     = ST_IDLE;
          lane_full_d = {NUM_LANES{1'b0}};
          for (int i = 0; i < NUM_LANES; i++) begin
            timer_d[i] = TIMER_ZERO;
          end
        end else begin
          state_d     = ST_OVER;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        lane_full_d = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
          timer_d[i] = TIMER_ZERO;
        end
      end
    endcase

    q_idle_d = (state_d == ST_IDLE);
    q_run_d  = (state_d == ST_RUN);
    q_over_d = (state_d == ST_OVER);
  end

  // State, lane, timer and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      q_idle_q    <= 1'b1;
      q_run_q     <= 1'b0;
      q_over_q    <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      lane_full_q <= {NUM_LANES{1'b0}};
      kills_q     <= 8'd0;
      over_lane_q <= {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        timer_q[i] <= TIMER_ZERO;
      end
    end else begin
      state_q     <= state_d;
      q_idle_q    <= q_idle_d;
      q_run_q     <= q_run_d;
      q_over_q    <= q_over_d;
      lfsr_q      <= lfsr_d;
      lane_full_q <= lane_full_d;
      kills_q     <= kills_d;
      over_lane_q <= over_lane_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign q_idle    = q_idle_q;
  assign q_run     = q_run_q;
  assign q_over    = q_over_q;
  assign game_over = q_over_q;
  assign lane_full = lane_full_q;
  assign kills     = kills_q;
  assign over_lane = over_lane_q;

endmodule

// File: tb/tb_monster_lane_ctrl.sv
// -----------------------------------------------------------------------------
// tb_monster_lane_ctrl
//   Directed bench for monster_lane_ctrl. Five instances with different
//   parameter sets share clock, reset and tick; each has its own play/shoot
//   and is exercised in turn while the others sit idle.
//     u_a : THRESH=256 MAX_ACTIVE=2 ATTACK=1000  (grant limit, reset, kills)
//     u_b : THRESH=256 MAX_ACTIVE=4 ATTACK=3     (multi-lane expiry)
//     u_c : THRESH=256 MAX_ACTIVE=1 ATTACK=2     (shoot vs. expiry race)
//     u_d : THRESH=0                              (never spawns, LFSR walk)
//     u_e : THRESH=128 MAX_ACTIVE=2 ATTACK=1000  (LFSR-driven spawn pattern)
// -----------------------------------------------------------------------------
module tb_monster_lane_ctrl;

  logic Clk;
  logic Reset;
  logic tick;

  logic       play_a, play_b, play_c, play_d, play_e;
  logic [3:0] shoot_a, shoot_b, shoot_c, shoot_d, shoot_e;

  logic       qi_a, qr_a, qo_a, go_a;
  logic [3:0] lf_a, ol_a;
  logic [7:0] k_a;
  logic       qi_b, qr_b, qo_b, go_b;
  logic [3:0] lf_b, ol_b;
  logic [7:0] k_b;
  logic       qi_c, qr_c, qo_c, go_c;
  logic [3:0] lf_c, ol_c;
  logic [7:0] k_c;
  logic       qi_d, qr_d, qo_d, go_d;
  logic [3:0] lf_d, ol_d;
  logic [7:0] k_d;
  logic       qi_e, qr_e, qo_e, go_e;
  logic [3:0] lf_e, ol_e;
  logic [7:0] k_e;

  int checks   = 0;
  int failures = 0;
  int lfsr_zero_seen = 0;
  int lane_seen      = 0;

  monster_lane_ctrl #(.NUM_LANES(4), .TIMER_W(16), .ATTACK_TICKS(1000),
    .SPAWN_THRESH(256), .MAX_ACTIVE(2), .LFSR_SEED(8'hA5)) u_a (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play_a), .shoot(shoot_a),
    .q_idle(qi_a), .q_run(qr_a), .q_over(qo_a), .lane_full(lf_a),
    .kills(k_a), .game_over(go_a), .over_lane(ol_a));

  monster_lane_ctrl #(.NUM_LANES(4), .TIMER_W(16), .ATTACK_TICKS(3),
    .SPAWN_THRESH(256), .MAX_ACTIVE(4), .LFSR_SEED(8'hA5)) u_b (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play_b), .shoot(shoot_b),
    .q_idle(qi_b), .q_run(qr_b), .q_over(qo_b), .lane_full(lf_b),
    .kills(k_b), .game_over(go_b), .over_lane(ol_b));

  monster_lane_ctrl #(.NUM_LANES(4), .TIMER_W(16), .ATTACK_TICKS(2),
    .SPAWN_THRESH(256), .MAX_ACTIVE(1), .LFSR_SEED(8'hA5)) u_c (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play_c), .shoot(shoot_c),
    .q_idle(qi_c), .q_run(qr_c), .q_over(qo_c), .lane_full(lf_c),
    .kills(k_c), .game_over(go_c), .over_lane(ol_c));

  monster_lane_ctrl #(.NUM_LANES(4), .TIMER_W(16), .ATTACK_TICKS(1000),
    .SPAWN_THRESH(0), .MAX_ACTIVE(2), .LFSR_SEED(8'hA5)) u_d (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play_d), .shoot(shoot_d),
    .q_idle(qi_d), .q_run(qr_d), .q_over(qo_d), .lane_full(lf_d),
    .kills(k_d), .game_over(go_d), .over_lane(ol_d));

  monster_lane_ctrl #(.NUM_LANES(4), .TIMER_W(16), .ATTACK_TICKS(1000),
    .SPAWN_THRESH(128), .MAX_ACTIVE(2), .LFSR_SEED(8'hA5)) u_e (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play_e), .shoot(shoot_e),
    .q_idle(qi_e), .q_run(qr_e), .q_over(qo_e), .lane_full(lf_e),
    .kills(k_e), .game_over(go_e), .over_lane(ol_e));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs settle 1 time unit after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle tick pulse followed by one quiet cycle
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  initial begin
    Reset = 1'b1; tick = 1'b0;
    play_a = 1'b0; play_b = 1'b0; play_c = 1'b0; play_d = 1'b0; play_e = 1'b0;
    shoot_a = 4'd0; shoot_b = 4'd0; shoot_c = 4'd0; shoot_d = 4'd0; shoot_e = 4'd0;

    // ---------------- reset state ----------------
    step();
    check("rst_q_idle",    {31'd0, qi_a}, 32'd1);
    check("rst_q_run",     {31'd0, qr_a}, 32'd0);
    check("rst_q_over",    {31'd0, qo_a}, 32'd0);
    check("rst_lane_full", {28'd0, lf_a}, 32'd0);
    check("rst_kills",     {24'd0, k_a},  32'd0);
    check("rst_game_over", {31'd0, go_a}, 32'd0);
    check("rst_over_lane", {28'd0, ol_a}, 32'd0);
    step();
    Reset = 1'b0;
    step();

    // shoot while idle does nothing
    shoot_a = 4'b1111; step(); shoot_a = 4'd0;
    check("idle_shoot_kills", {24'd0, k_a},  32'd0);
    check("idle_shoot_lanes", {28'd0, lf_a}, 32'd0);

    // ---------------- u_a: grant limit ----------------
    play_a = 1'b1; step();
    check("a_run_flag",  {31'd0, qr_a}, 32'd1);
    check("a_idle_flag", {31'd0, qi_a}, 32'd0);
    do_tick();
    check("a_first_tick_lanes", {28'd0, lf_a}, 32'h3);
    shoot_a = 4'b0100; step(); shoot_a = 4'd0;
    check("a_shoot_empty_kills", {24'd0, k_a},  32'd0);
    check("a_shoot_empty_lanes", {28'd0, lf_a}, 32'h3);
    shoot_a = 4'b0011; step(); shoot_a = 4'd0;
    check("a_kill2_kills", {24'd0, k_a},  32'd2);
    check("a_kill2_lanes", {28'd0, lf_a}, 32'h0);
    do_tick();
    check("a_respawn_lanes", {28'd0, lf_a}, 32'h3);
    shoot_a = 4'b0011; step(); shoot_a = 4'd0;
    do_tick();
    shoot_a = 4'b0001; step(); shoot_a = 4'd0;
    check("a_kills5",        {24'd0, k_a},  32'd5);
    check("a_kills5_lanes",  {28'd0, lf_a}, 32'h2);

    // ---------------- async reset mid-RUN ----------------
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_kills", {24'd0, k_a},        32'd0);
    check("midrst_idle",  {31'd0, qi_a},       32'd1);
    check("midrst_run",   {31'd0, qr_a},       32'd0);
    check("midrst_lanes", {28'd0, lf_a},       32'd0);
    check("midrst_lfsr",  {24'd0, u_a.lfsr_q}, 32'hA5);
    play_a = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();
    check("postrst_idle", {31'd0, qi_a}, 32'd1);

    // ---------------- u_a: kill saturation ----------------
    play_a = 1'b1; step();
    for (int i = 0; i < 127; i++) begin
      do_tick();
      shoot_a = 4'b0011; step(); shoot_a = 4'd0;
    end
    check("a_kills_254", {24'd0, k_a}, 32'd254);
    for (int i = 0; i < 23; i++) begin
      do_tick();
      shoot_a = 4'b0011; step(); shoot_a = 4'd0;
    end
    check("a_kills_sat", {24'd0, k_a}, 32'd255);
    do_tick();
    for (int i = 0; i < 999; i++) begin
      do_tick();
    end
    check("a_not_yet_over", {31'd0, go_a}, 32'd0);
    do_tick();
    check("a_over",           {31'd0, go_a}, 32'd1);
    check("a_over_flag",      {31'd0, qo_a}, 32'd1);
    check("a_over_lane",      {28'd0, ol_a}, 32'h3);
    check("a_over_kills",     {24'd0, k_a},  32'd255);
    play_a = 1'b0; step();
    check("a_back_idle",      {31'd0, qi_a}, 32'd1);
    check("a_idle_kills_held",{24'd0, k_a},  32'd255);
    check("a_idle_lanes",     {28'd0, lf_a}, 32'd0);
    play_a = 1'b1; step();
    check("a_rerun_flag",     {31'd0, qr_a}, 32'd1);
    check("a_rerun_kills",    {24'd0, k_a},  32'd0);
    check("a_rerun_overlane", {28'd0, ol_a}, 32'd0);
    play_a = 1'b0; step();

    // ---------------- u_b: multi-lane expiry ----------------
    play_b = 1'b1; step();
    do_tick();
    check("b_all_full", {28'd0, lf_b}, 32'hF);
    shoot_b = 4'b0100; step(); shoot_b = 4'd0;
    check("b_kill_lane2", {24'd0, k_b},  32'd1);
    check("b_lanes_1011", {28'd0, lf_b}, 32'hB);
    do_tick();
    check("b_respawn",   {28'd0, lf_b}, 32'hF);
    do_tick();
    check("b_tick3_run", {31'd0, go_b}, 32'd0);
    do_tick();
    check("b_over",      {31'd0, go_b}, 32'd1);
    check("b_over_lane", {28'd0, ol_b}, 32'hB);
    check("b_run_clear", {31'd0, qr_b}, 32'd0);
    shoot_b = 4'b1111; step(); shoot_b = 4'd0;
    check("b_over_shoot_kills", {24'd0, k_b}, 32'd1);
    play_b = 1'b0; step();
    check("b_idle", {31'd0, qi_b}, 32'd1);

    // ---------------- u_c: shoot beats expiry ----------------
    play_c = 1'b1; step();
    do_tick();
    check("c_lane0_full", {28'd0, lf_c}, 32'h1);
    do_tick();
    tick = 1'b1; shoot_c = 4'b0001;
    step();
    tick = 1'b0; shoot_c = 4'd0;
    check("c_race_lanes", {28'd0, lf_c}, 32'h2);
    check("c_race_kills", {24'd0, k_c},  32'd1);
    check("c_race_no_go", {31'd0, go_c}, 32'd0);
    step();
    do_tick();
    check("c_lane1_alive", {31'd0, go_c}, 32'd0);
    do_tick();
    check("c_lane1_over",  {31'd0, go_c}, 32'd1);
    check("c_over_lane",   {28'd0, ol_c}, 32'h2);
    play_c = 1'b0; step();

    // ---------------- u_e: LFSR-driven spawns ----------------
    play_e = 1'b1; step();
    do_tick();
    check("e_tick1_lanes", {28'd0, lf_e}, 32'h8);
    do_tick();
    check("e_tick2_lanes", {28'd0, lf_e}, 32'h9);
    play_e = 1'b0; step();
    check("e_idle_clear", {28'd0, lf_e}, 32'h0);

    // ---------------- u_d: threshold 0 ----------------
    play_d = 1'b1; step();
    do_tick();
    check("d_lfsr_1", {24'd0, u_d.lfsr_q}, 32'h4A);
    do_tick();
    check("d_lfsr_2", {24'd0, u_d.lfsr_q}, 32'h95);
    for (int i = 0; i < 9998; i++) begin
      do_tick();
      if (u_d.lfsr_q == 8'd0) lfsr_zero_seen++;
      if (lf_d != 4'd0 || go_d != 1'b0) lane_seen++;
    end
    check("d_lfsr_never_zero", lfsr_zero_seen, 32'd0);
    check("d_never_spawned",   lane_seen,      32'd0);
    check("d_lanes_empty",     {28'd0, lf_d},  32'd0);
    check("d_no_game_over",    {31'd0, go_d},  32'd0);
    check("d_still_run",       {31'd0, qr_d},  32'd1);
    play_d = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
